// File: rtl/vga_scan_dither.sv
// VGA scan counters, sync/active alignment pipeline and ordered-dither colour output stage.
// Colour is accepted PIX_LATENCY cycles after its count and leaves on registered pins.
module vga_scan_dither #(
   parameter int H_DISPLAY   = 1220,
   parameter int H_FRONT     = 31,
   parameter int H_SYNC      = 183,
   parameter int H_BACK      = 91,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int IN_BITS     = 6,
   parameter int OUT_BITS    = 2,
   parameter int PIX_LATENCY = 2,
   parameter bit SYNC_POL    = 1'b0
) (
   input  logic                clk48,
   input  logic                rst_n,
   input  logic [1:0]          dither_mode,
   output logic [10:0]         h_count,
   output logic [9:0]          v_count,
   output logic [10:0]         frame,
   output logic                line_start,
   output logic                frame_start,
   output logic                pix_active,
   input  logic [IN_BITS-1:0]  r_in,
   input  logic [IN_BITS-1:0]  g_in,
   input  logic [IN_BITS-1:0]  b_in,
   output logic                hsync,
   output logic                vsync,
   output logic [OUT_BITS-1:0] r_out,
   output logic [OUT_BITS-1:0] g_out,
   output logic [OUT_BITS-1:0] b_out
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int D       = IN_BITS - OUT_BITS;
   localparam int OUT_MAX = (2 ** OUT_BITS) - 1;
   localparam int PW      = 10;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_DISP_W   = 11'(H_DISPLAY);
   localparam logic [9:0]  V_DISP_W   = 10'(V_DISPLAY);
   localparam logic [10:0] HS_START_W = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_END_W   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0]  VS_START_W = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0]  VS_END_W   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [10:0]         h_count_r;
   logic [9:0]          v_count_r;
   logic [10:0]         frame_r;
   logic [1:0]          mode_q_r;
   logic                hsync_r;
   logic                vsync_r;
   logic [OUT_BITS-1:0] r_out_r;
   logic [OUT_BITS-1:0] g_out_r;
   logic [OUT_BITS-1:0] b_out_r;

   logic                line_start_s;
   logic                frame_start_s;
   logic                active_s;
   logic                hs_raw_s;
   logic                vs_raw_s;
   logic [PW-1:0]       live_word_s;
   logic [PW-1:0]       tap_word_s;
   logic                tap_active_s;
   logic                tap_hs_s;
   logic                tap_vs_s;
   logic [2:0]          tap_h_s;
   logic [2:0]          tap_v_s;
   logic                tap_f_s;
   logic [2:0]          tap_h_t_s;
   logic [1:0]          mode_use_s;
   logic [5:0]          m_s;
   logic [IN_BITS-1:0]  thr_s;

   // Add the threshold with one bit of headroom, drop D bits, clamp to full scale.
   function automatic logic [OUT_BITS-1:0] dither_ch(input logic [IN_BITS-1:0] c,
                                                      input logic [IN_BITS-1:0] t);
      logic [IN_BITS:0] sum;
      logic [IN_BITS:0] shifted;
      sum     = {1'b0, c} + {1'b0, t};
      shifted = sum >> D;
      if (shifted > (IN_BITS+1)'(OUT_MAX)) begin
         dither_ch = {OUT_BITS{1'b1}};
      end else begin
         dither_ch = shifted[OUT_BITS-1:0];
      end
   endfunction

   // Scan counters: h every clock, v on line wrap, frame on field wrap
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         h_count_r <= 11'd0;
         v_count_r <= 10'd0;
         frame_r   <= 11'd0;
      end else if (h_count_r == H_LAST) begin
         h_count_r <= 11'd0;
         if (v_count_r == V_LAST) begin
            v_count_r <= 10'd0;
            frame_r   <= frame_r + 11'd1;
         end else begin
            v_count_r <= v_count_r + 10'd1;
         end
      end else begin
         h_count_r <= h_count_r + 11'd1;
      end
   end

   // Live count decode; the pulses stay low while reset is held
   always_comb begin
      line_start_s  = rst_n && (h_count_r == 11'd0);
      frame_start_s = rst_n && (h_count_r == 11'd0) && (v_count_r == 10'd0);
      active_s      = (h_count_r < H_DISP_W) && (v_count_r < V_DISP_W);
      hs_raw_s      = (h_count_r >= HS_START_W) && (h_count_r < HS_END_W);
      vs_raw_s      = (v_count_r >= VS_START_W) && (v_count_r < VS_END_W);
      live_word_s   = {active_s, hs_raw_s, vs_raw_s, h_count_r[2:0], v_count_r[2:0], frame_r[0]};
   end

   generate
      if (PIX_LATENCY == 0) begin : g_no_delay
         assign tap_word_s = live_word_s;
      end else begin : g_delay
         logic [PW-1:0] pipe_r [PIX_LATENCY];

         // Alignment shift register; cleared words read as blank with syncs idle
         always_ff @(posedge clk48 or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < PIX_LATENCY; k++) begin
                  pipe_r[k] <= '0;
               end
            end else begin
               pipe_r[0] <= live_word_s;
               for (int k = 1; k < PIX_LATENCY; k++) begin
                  pipe_r[k] <= pipe_r[k-1];
               end
            end
         end

         assign tap_word_s = pipe_r[PIX_LATENCY-1];
      end
   endgenerate

   assign tap_active_s = tap_word_s[9];
   assign tap_hs_s     = tap_word_s[8];
   assign tap_vs_s     = tap_word_s[7];
   assign tap_h_s      = tap_word_s[6:4];
   assign tap_v_s      = tap_word_s[3:1];
   assign tap_f_s      = tap_word_s[0];

   // Dither mode latches only at the top of a frame
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         mode_q_r <= 2'b00;
      end else if (frame_start_s) begin
         mode_q_r <= dither_mode;
      end else begin
         mode_q_r <= mode_q_r;
      end
   end

   // Bayer threshold for the delayed position; with zero latency pixel (0,0) needs the new mode
   always_comb begin
      if ((PIX_LATENCY == 0) && frame_start_s) begin
         mode_use_s = dither_mode;
      end else begin
         mode_use_s = mode_q_r;
      end
      tap_h_t_s = tap_h_s ^ {3{tap_f_s}};
      case (mode_use_s)
         2'b01: m_s = {tap_h_s[0] ^ tap_v_s[0], tap_h_s[0],
                       tap_h_s[1] ^ tap_v_s[1], tap_h_s[1],
                       tap_h_s[2] ^ tap_v_s[2], tap_h_s[2]};
         2'b10: m_s = {tap_h_t_s[0] ^ tap_v_s[0], tap_h_t_s[0],
                       tap_h_t_s[1] ^ tap_v_s[1], tap_h_t_s[1],
                       tap_h_t_s[2] ^ tap_v_s[2], tap_h_t_s[2]};
         2'b11: m_s = {tap_h_s[0] ^ tap_v_s[0], tap_h_s[0],
                       tap_h_s[1] ^ tap_v_s[1], tap_h_s[1], 2'b00};
         default: m_s = 6'd0;
      endcase
      thr_s = IN_BITS'(m_s >> (6 - D));
   end

   // Pin register: syncs in their polarity, colour dithered or blanked
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         hsync_r <= ~SYNC_POL;
         vsync_r <= ~SYNC_POL;
         r_out_r <= '0;
         g_out_r <= '0;
         b_out_r <= '0;
      end else begin
         hsync_r <= SYNC_POL ? tap_hs_s : ~tap_hs_s;
         vsync_r <= SYNC_POL ? tap_vs_s : ~tap_vs_s;
         if (tap_active_s) begin
            r_out_r <= dither_ch(r_in, thr_s);
            g_out_r <= dither_ch(g_in, thr_s);
            b_out_r <= dither_ch(b_in, thr_s);
         end else begin
            r_out_r <= '0;
            g_out_r <= '0;
            b_out_r <= '0;
         end
      end
   end

   assign h_count     = h_count_r;
   assign v_count     = v_count_r;
   assign frame       = frame_r;
   assign line_start  = line_start_s;
   assign frame_start = frame_start_s;
   assign pix_active  = active_s;
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign r_out       = r_out_r;
   assign g_out       = g_out_r;
   assign b_out       = b_out_r;

endmodule

// File: tb/tb_vga_scan_dither.sv
// Directed bench: default-timing instance for line timing, a 16x12 instance for dither/vsync,
// and a 4x4 instance so the frame counter can wrap in a short run.
module tb_vga_scan_dither;

   logic       clk48 = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dither_mode = 2'b00;
   logic [5:0] r_in = 6'd0;
   logic [5:0] g_in = 6'd0;
   logic [5:0] b_in = 6'd0;

   logic [10:0] a_h, b_h, c_h, a_frame, b_frame, c_frame;
   logic [9:0]  a_v, b_v, c_v;
   logic        a_ls, b_ls, c_ls, a_fs, b_fs, c_fs, a_act, b_act, c_act;
   logic        a_hsync, b_hsync, c_hsync, a_vsync, b_vsync, c_vsync;
   logic [1:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk48 = ~clk48;

   vga_scan_dither u_def (
      .clk48(clk48), .rst_n(rst_n), .dither_mode(dither_mode),
      .h_count(a_h), .v_count(a_v), .frame(a_frame),
      .line_start(a_ls), .frame_start(a_fs), .pix_active(a_act),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hsync(a_hsync), .vsync(a_vsync), .r_out(a_r), .g_out(a_g), .b_out(a_b)
   );

   vga_scan_dither #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) u_mid (
      .clk48(clk48), .rst_n(rst_n), .dither_mode(dither_mode),
      .h_count(b_h), .v_count(b_v), .frame(b_frame),
      .line_start(b_ls), .frame_start(b_fs), .pix_active(b_act),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hsync(b_hsync), .vsync(b_vsync), .r_out(b_r), .g_out(b_g), .b_out(b_b)
   );

   vga_scan_dither #(
      .H_DISPLAY(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(0),
      .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(0)
   ) u_tiny (
      .clk48(clk48), .rst_n(rst_n), .dither_mode(dither_mode),
      .h_count(c_h), .v_count(c_v), .frame(c_frame),
      .line_start(c_ls), .frame_start(c_fs), .pix_active(c_act),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hsync(c_hsync), .vsync(c_vsync), .r_out(c_r), .g_out(c_g), .b_out(c_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic adv1();
      @(negedge clk48);
      cyc = cyc + 1;
   endtask

   task automatic goto_cyc(input int target);
      while (cyc < target) adv1();
   endtask

   initial begin
      logic [1:0]  rec [64];
      logic [31:0] e;
      int          low_cnt;
      int          first_low;
      int          n3;
      int          ndiff;

      // Reset held
      r_in = 6'd63; g_in = 6'd47; b_in = 6'd0; dither_mode = 2'b00;
      repeat (3) @(posedge clk48);
      @(negedge clk48);
      check("rst_h", 32'(a_h), 32'd0);
      check("rst_frame", 32'(a_frame), 32'd0);
      check("rst_fs_low", 32'(a_fs), 32'd0);
      check("rst_hsync", 32'(a_hsync), 32'd1);
      check("rst_vsync", 32'(a_vsync), 32'd1);
      check("rst_r", 32'(a_r), 32'd0);

      // Release: first cycle shows count 0,0 with frame_start
      @(negedge clk48);
      rst_n = 1'b1;
      cyc = 0;
      #1;
      check("rel_fs", 32'(a_fs), 32'd1);
      check("rel_ls", 32'(a_ls), 32'd1);
      check("rel_act", 32'(a_act), 32'd1);
      check("rel_h", 32'(a_h), 32'd0);
      check("rel_v", 32'(a_v), 32'd0);
      check("rel_hsync", 32'(a_hsync), 32'd1);
      check("rel_r", 32'(a_r), 32'd0);
      goto_cyc(1);
      check("fs_one_cycle", 32'(a_fs), 32'd0);

      // Truncation in mode 00 (pins lag counts by 3 cycles)
      goto_cyc(5);
      check("trunc_63", 32'(a_r), 32'd3);
      check("trunc_47", 32'(a_g), 32'd2);
      check("trunc_0", 32'(a_b), 32'd0);
      goto_cyc(1222);
      check("last_active", 32'(a_r), 32'd3);
      goto_cyc(1223);
      check("first_blank", 32'(a_r), 32'd0);

      // hsync width and position on the default timing
      goto_cyc(1230);
      check("a_h_1230", 32'(a_h), 32'd1230);
      low_cnt = 0;
      first_low = -1;
      while (cyc < 1480) begin
         adv1();
         if (a_hsync == 1'b0) begin
            low_cnt = low_cnt + 1;
            if (first_low < 0) first_low = cyc;
         end
      end
      check("hsync_width", 32'(low_cnt), 32'd183);
      check("hsync_fall", 32'(first_low), 32'd1254);
      goto_cyc(1525);
      check("line1_h", 32'(a_h), 32'd0);
      check("line1_v", 32'(a_v), 32'd1);
      check("line1_ls", 32'(a_ls), 32'd1);

      // Mid-frame mode change on the 16x12 instance is held off
      goto_cyc(1540);
      r_in = 6'd40; g_in = 6'd63; b_in = 6'd0;
      goto_cyc(1588);
      dither_mode = 2'b01;
      goto_cyc(1621);
      check("midswitch_r", 32'(b_r), 32'd2);
      check("midswitch_g", 32'(b_g), 32'd3);
      check("mid_frame", 32'(b_frame), 32'd8);
      check("mid_v", 32'(b_v), 32'd5);
      check("mid_h", 32'(b_h), 32'd5);

      // Mode 01 over one full 8x8 tile of frame 9
      goto_cyc(1728);
      check("f9_fs", 32'(b_fs), 32'd1);
      n3 = 0;
      for (int v = 0; v < 8; v++) begin
         for (int h = 0; h < 8; h++) begin
            goto_cyc(1728 + v*16 + h + 3);
            e = (((h ^ v) & 1) != 0) ? 32'd3 : 32'd2;
            check("bayer8", 32'(b_r), e);
            if (b_r == 2'd3) n3 = n3 + 1;
         end
      end
      check("bayer8_threes", 32'(n3), 32'd32);
      goto_cyc(1851);
      check("mid_blank", 32'(b_r), 32'd0);

      // Mode 10: even frame 10 then odd frame 11
      goto_cyc(1860);
      dither_mode = 2'b10;
      n3 = 0;
      for (int v = 0; v < 8; v++) begin
         for (int h = 0; h < 8; h++) begin
            goto_cyc(1920 + v*16 + h + 3);
            rec[v*8 + h] = b_r;
            if (b_r == 2'd3) n3 = n3 + 1;
         end
      end
      check("temporal_even_threes", 32'(n3), 32'd32);
      check("temporal_even_1_0", 32'(rec[1]), 32'd3);
      ndiff = 0;
      for (int v = 0; v < 8; v++) begin
         for (int h = 0; h < 8; h++) begin
            goto_cyc(2112 + v*16 + h + 3);
            e = (((h ^ v) & 1) != 0) ? 32'd2 : 32'd3;
            check("temporal_odd", 32'(b_r), e);
            if (b_r != rec[v*8 + h]) ndiff = ndiff + 1;
            if ((h == 0) && (v == 0)) check("temporal_g_sat", 32'(b_g), 32'd3);
         end
      end
      check("temporal_diff", 32'(ndiff), 32'd64);

      // Mode 11 in frame 12, plus vsync on lines 9 and 10
      goto_cyc(2240);
      dither_mode = 2'b11;
      goto_cyc(2307);
      check("b4_0_0", 32'(b_r), 32'd2);
      goto_cyc(2308);
      check("b4_1_0", 32'(b_r), 32'd3);
      goto_cyc(2323);
      check("b4_0_1", 32'(b_r), 32'd3);
      check("b4_g_sat", 32'(b_g), 32'd3);
      goto_cyc(2324);
      check("b4_1_1", 32'(b_r), 32'd2);
      goto_cyc(2450);
      check("vs_line8", 32'(b_vsync), 32'd1);
      goto_cyc(2451);
      check("vs_line9", 32'(b_vsync), 32'd0);
      goto_cyc(2482);
      check("vs_line10", 32'(b_vsync), 32'd0);
      goto_cyc(2483);
      check("vs_line11", 32'(b_vsync), 32'd1);
      goto_cyc(2490);
      dither_mode = 2'b00;

      // Frame counter wrap on the 4x4 instance (16 cycles per frame)
      goto_cyc(32767);
      check("wrap_pre_frame", 32'(c_frame), 32'd2047);
      check("wrap_pre_fs", 32'(c_fs), 32'd0);
      goto_cyc(32768);
      check("wrap_frame", 32'(c_frame), 32'd0);
      check("wrap_fs", 32'(c_fs), 32'd1);

      // Reset mid-line
      goto_cyc(32770);
      check("pre_rst_r", 32'(a_r), 32'd2);
      check("pre_rst_h", 32'(a_h), 32'd745);
      check("pre_rst_v", 32'(a_v), 32'd21);
      rst_n = 1'b0;
      #1;
      check("async_h", 32'(a_h), 32'd0);
      check("async_r", 32'(a_r), 32'd0);
      check("async_hsync", 32'(a_hsync), 32'd1);
      check("async_b_frame", 32'(b_frame), 32'd0);
      check("async_fs", 32'(a_fs), 32'd0);
      repeat (2) @(posedge clk48);
      @(negedge clk48);
      rst_n = 1'b1;
      cyc = 0;
      #1;
      check("rerel_fs", 32'(a_fs), 32'd1);
      check("rerel_h", 32'(a_h), 32'd0);
      goto_cyc(2);
      check("refill_blank", 32'(a_r), 32'd0);
      goto_cyc(3);
      check("refill_first", 32'(a_r), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
